// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-channel UART transmit scheduler.
//   Two producers push bytes through valid/ready ports into a shared byte
//   FIFO (round-robin on contention, one push per cycle). An FSM drains the
//   FIFO over an MMIO master port: it reads the UART status register until
//   the busy bit is clear, then writes the head byte to the TX register.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s0_*/s1_*             producer channels (valid, data[7:0], ready)
//   m_req/m_we/m_addr/m_wdata  registered MMIO request
//   m_rdata/m_ready       MMIO response
//   fifo_level            FIFO occupancy, idle = FIFO empty and FSM in IDLE
// Optional: define UART_SCHED_STATS_EN to add sent_cnt / retry_cnt outputs.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h4000_0000
`endif
`ifndef IO_UART_TX_OFFSET
`define IO_UART_TX_OFFSET 32'h0
`endif
`ifndef IO_UART_STAT_OFFSET
`define IO_UART_STAT_OFFSET 32'h4
`endif
`ifndef IO_UART_STAT_BUSY_BIT
`define IO_UART_STAT_BUSY_BIT 3
`endif

module uart_tx_sched #(
  parameter int                 FIFO_DEPTH = 4,
  parameter int                 POLL_GAP   = 2,
  parameter logic [`ADDR_W-1:0] STAT_ADDR  = `IO_BASE_ADDR + `IO_UART_STAT_OFFSET,
  parameter logic [`ADDR_W-1:0] TX_ADDR    = `IO_BASE_ADDR + `IO_UART_TX_OFFSET
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s0_valid,
  input  logic [7:0]                  s0_data,
  output logic                        s0_ready,
  input  logic                        s1_valid,
  input  logic [7:0]                  s1_data,
  output logic                        s1_ready,
  output logic                        m_req,
  output logic                        m_we,
  output logic [`ADDR_W-1:0]          m_addr,
  output logic [`XLEN-1:0]            m_wdata,
  input  logic [`XLEN-1:0]            m_rdata,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        idle
`ifdef UART_SCHED_STATS_EN
  ,
  output logic [31:0]                 sent_cnt,
  output logic [31:0]                 retry_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_POLL, S_GAP, S_WRITE} state_t;

  state_t              state_q;
  logic                m_req_q, m_we_q;
  logic [`ADDR_W-1:0]  m_addr_q;
  logic [`XLEN-1:0]    m_wdata_q;
  logic [GW-1:0]       gap_q;

  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [LW-1:0]       cnt_q;
  logic                last_q;   // channel of the last accepted push (1 = ch1)

  logic full, empty, acc0, acc1, push, pop, busy;
  logic [7:0] push_data;
  logic unused_rdata;

  assign full  = (cnt_q == LW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);

  // A channel may take the slot when the other is silent or it holds the
  // round-robin turn; with both valid exactly one ready is high.
  assign s0_ready = !full && (!s1_valid || last_q);
  assign s1_ready = !full && (!s0_valid || !last_q);

  assign acc0      = s0_valid && s0_ready;
  assign acc1      = s1_valid && s1_ready;
  assign push      = acc0 || acc1;
  assign push_data = acc0 ? s0_data : s1_data;
  assign pop       = (state_q == S_WRITE) && m_ready;
  assign busy      = m_rdata[`IO_UART_STAT_BUSY_BIT];
  assign unused_rdata = ^m_rdata;

  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign fifo_level = cnt_q;
  assign idle       = empty && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= 1'b1;  // so ch0 wins the first contention
    end else begin
      if (push) begin
        wr_q   <= wr_q + 1'b1;
        last_q <= acc1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      gap_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (!empty) state_q <= S_POLL;
        S_POLL: begin
          if (!m_req_q) begin
            // first cycle after IDLE: launch the status read
            m_req_q  <= 1'b1;
            m_we_q   <= 1'b0;
            m_addr_q <= STAT_ADDR;
          end else if (m_ready) begin
            if (!busy) begin
              m_we_q    <= 1'b1;
              m_addr_q  <= TX_ADDR;
              m_wdata_q <= {{(`XLEN-8){1'b0}}, mem_q[rd_q]};
              state_q   <= S_WRITE;
            end else if (POLL_GAP > 0) begin
              m_req_q  <= 1'b0;
              m_addr_q <= '0;
              gap_q    <= '0;
              state_q  <= S_GAP;
            end
            // busy with no gap: request stays up for a back-to-back poll
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q    <= '0;
            m_req_q  <= 1'b1;
            m_addr_q <= STAT_ADDR;
            state_q  <= S_POLL;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (m_ready) begin
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef UART_SCHED_STATS_EN
  logic [31:0] sent_q, retry_q;
  assign sent_cnt  = sent_q;
  assign retry_cnt = retry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q  <= '0;
      retry_q <= '0;
    end else begin
      if (pop) sent_q <= sent_q + 1'b1;
      if ((state_q == S_POLL) && m_req_q && m_ready && busy) retry_q <= retry_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h4000_0000
`endif
`ifndef IO_UART_TX_OFFSET
`define IO_UART_TX_OFFSET 32'h0
`endif
`ifndef IO_UART_STAT_OFFSET
`define IO_UART_STAT_OFFSET 32'h4
`endif
`ifndef IO_UART_STAT_BUSY_BIT
`define IO_UART_STAT_BUSY_BIT 3
`endif

module tb_uart_tx_sched;
  localparam logic [31:0] S = `IO_BASE_ADDR + `IO_UART_STAT_OFFSET;
  localparam logic [31:0] T = `IO_BASE_ADDR + `IO_UART_TX_OFFSET;
  localparam int GAP = 2;

  logic clk = 0, rst = 1;
  logic s0_valid = 0, s1_valid = 0, s0_ready, s1_ready;
  logic [7:0] s0_data = 0, s1_data = 0;
  logic m_req, m_we, m_ready;
  logic [`ADDR_W-1:0] m_addr;
  logic [`XLEN-1:0] m_wdata, m_rdata;
  logic [2:0] fifo_level;
  logic idle;
`ifdef UART_SCHED_STATS_EN
  logic [31:0] sent_cnt, retry_cnt;
`endif

  uart_tx_sched #(.FIFO_DEPTH(4), .POLL_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .fifo_level(fifo_level), .idle(idle)
`ifdef UART_SCHED_STATS_EN
    , .sent_cnt(sent_cnt), .retry_cnt(retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  // slave model: reads always complete at once; writes when wr_rdy
  logic stall = 0, wr_rdy = 1;
  int   busy_target = 0, busy_done = 0, cyc = 0;
  assign m_ready = m_req && (m_we ? wr_rdy : 1'b1);
  assign m_rdata = (stall || busy_done < busy_target) ? (`XLEN'(1) << `IO_UART_STAT_BUSY_BIT) : '0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } txn_t;
  txn_t txq[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_req && m_ready) begin
      txq.push_back('{m_we, 32'(m_addr), 32'(m_wdata), cyc});
      if (!m_we && m_rdata[`IO_UART_STAT_BUSY_BIT]) busy_done <= busy_done + 1;
    end
  end

  int vec_cnt = 0, err_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int count_we(int start, bit we);
    int n = 0;
    for (int k = start; k < txq.size(); k++) if (txq[k].we == we) n++;
    return n;
  endfunction

  task automatic do_reset();
    s0_valid = 0; s1_valid = 0; rst = 1;
    @(posedge clk); @(posedge clk); #1 rst = 0;
  endtask

  task automatic push0(logic [7:0] d);
    s0_valid = 1; s0_data = d;
    @(posedge clk); #1 s0_valid = 0;
  endtask

  task automatic wait_wr(int start, int n, string name);
    int c = 0;
    while (count_we(start, 1) < n && c < 300) begin @(posedge clk); #1 c++; end
    check(name, 32'(count_we(start, 1)), 32'(n));
  endtask

  typedef struct {
    logic s0v; logic [7:0] s0d; logic s1v; logic [7:0] s1d;
    logic e0r, e1r; int elvl; logic ereq, ewe; logic [31:0] eaddr, ewd; logic eidle;
  } vec_t;

  function automatic vec_t mk(logic s0v, logic [7:0] s0d, logic s1v, logic [7:0] s1d,
                              logic e0r, logic e1r, int elvl, logic ereq, logic ewe,
                              logic [31:0] eaddr, logic [31:0] ewd, logic eidle);
    vec_t v;
    v = '{s0v, s0d, s1v, s1d, e0r, e1r, elvl, ereq, ewe, eaddr, ewd, eidle};
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    int start, n0, n1, bad, first_wr;
    logic a0, a1;
    int rd_cyc[$];
    logic [7:0] wr_seq[$];
    logic [7:0] exp_ab[6];

    //              s0v s0d    s1v s1d    s0r s1r lvl req we addr   wdata idle
    tbl[0]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0,  1);
    tbl[1]  = mk(1, 8'h41, 0, 8'h00, 1, 0, 0, 0, 0, 32'h0, 32'h0,  1);
    tbl[2]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 32'h0, 32'h0,  0);
    tbl[3]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 32'h0, 32'h0,  0);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 0, S,     32'h0,  0);
    tbl[5]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 1, T,     32'h41, 0);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0,  1);
    tbl[7]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0,  1);
    tbl[8]  = mk(1, 8'h51, 1, 8'h61, 0, 1, 0, 0, 0, 32'h0, 32'h0,  1);
    tbl[9]  = mk(1, 8'h51, 1, 8'h62, 1, 0, 1, 0, 0, 32'h0, 32'h0,  0);
    tbl[10] = mk(0, 8'h00, 0, 8'h00, 1, 1, 2, 0, 0, 32'h0, 32'h0,  0);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 1, 1, 2, 1, 0, S,     32'h0,  0);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 1, 1, 2, 1, 1, T,     32'h61, 0);
    tbl[13] = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 32'h0, 32'h0,  0);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 32'h0, 32'h0,  0);
    tbl[15] = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 0, S,     32'h0,  0);
    tbl[16] = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 1, T,     32'h51, 0);
    tbl[17] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0,  1);

    do_reset();

    // ---- table: reset state, single byte, arbitration, in-order drain
    for (int i = 0; i < 18; i++) begin
      s0_valid = tbl[i].s0v; s0_data = tbl[i].s0d;
      s1_valid = tbl[i].s1v; s1_data = tbl[i].s1d;
      @(negedge clk);
      vec_cnt++;
      if (s0_ready !== tbl[i].e0r || s1_ready !== tbl[i].e1r || int'(fifo_level) != tbl[i].elvl ||
          m_req !== tbl[i].ereq || m_we !== tbl[i].ewe || 32'(m_addr) !== tbl[i].eaddr ||
          32'(m_wdata) !== tbl[i].ewd || idle !== tbl[i].eidle) begin
        err_cnt++;
        $display("FAIL vec%0d: got s0r=%b s1r=%b lvl=%0d req=%b we=%b addr=%h wd=%h idle=%b expected s0r=%b s1r=%b lvl=%0d req=%b we=%b addr=%h wd=%h idle=%b",
                 i, s0_ready, s1_ready, fifo_level, m_req, m_we, m_addr, m_wdata, idle,
                 tbl[i].e0r, tbl[i].e1r, tbl[i].elvl, tbl[i].ereq, tbl[i].ewe, tbl[i].eaddr, tbl[i].ewd, tbl[i].eidle);
      end
      @(posedge clk); #1;
    end
    s0_valid = 0; s1_valid = 0;

    // ---- busy for 3 polls with a 2-cycle gap
    start = txq.size();
    busy_target = busy_done + 3;
    push0(8'h5A);
    wait_wr(start, 1, "busy_writes");
    for (int k = start; k < txq.size(); k++) if (!txq[k].we) rd_cyc.push_back(txq[k].cyc);
    check("busy_reads", 32'(rd_cyc.size()), 32'd4);
    for (int k = 1; k < rd_cyc.size(); k++)
      check($sformatf("poll_spacing%0d", k), 32'(rd_cyc[k] - rd_cyc[k-1]), 32'(GAP + 1));
    check("busy_rd_addr", txq[start].addr, S);
    for (int k = start; k < txq.size(); k++)
      if (txq[k].we) begin
        check("busy_wr_addr", txq[k].addr, T);
        check("busy_wr_data", txq[k].wdata, 32'h5A);
      end
`ifdef UART_SCHED_STATS_EN
    check("retry_cnt", retry_cnt, 32'd3);
    check("sent_cnt", sent_cnt, 32'd4);
`endif

    // ---- both channels streaming: strict alternation
    do_reset();
    start = txq.size();
    n0 = 0; n1 = 0;
    s0_data = 8'h10; s1_data = 8'h20; s0_valid = 1; s1_valid = 1;
    for (int c = 0; c < 400 && (n0 < 3 || n1 < 3); c++) begin
      @(negedge clk);
      a0 = s0_valid && s0_ready; a1 = s1_valid && s1_ready;
      check("one_grant", 32'(a0 && a1), 32'd0);
      @(posedge clk); #1;
      if (a0) begin n0++; s0_data++; if (n0 == 3) s0_valid = 0; end
      if (a1) begin n1++; s1_data++; if (n1 == 3) s1_valid = 0; end
    end
    check("rr_accepts", 32'(n0 + n1), 32'd6);
    wait_wr(start, 6, "rr_writes");
    exp_ab = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    for (int k = start; k < txq.size(); k++) if (txq[k].we) wr_seq.push_back(txq[k].wdata[7:0]);
    for (int k = 0; k < 6 && k < wr_seq.size(); k++)
      check($sformatf("rr_order%0d", k), 32'(wr_seq[k]), 32'(exp_ab[k]));

    // ---- fill to full while UART busy, then release
    do_reset();
    start = txq.size();
    stall = 1; n0 = 0; first_wr = -1;
    s0_valid = 1; s0_data = 8'h30;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); a0 = s0_valid && s0_ready;
      @(posedge clk); #1;
      if (a0) begin n0++; s0_data++; end
    end
    @(negedge clk);
    check("full_accepts", 32'(n0), 32'd4);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_readies", 32'({s0_ready, s1_ready}), 32'd0);
    check("full_no_write", 32'(count_we(start, 1)), 32'd0);
    @(posedge clk); #1 stall = 0;
    for (int c = 0; c < 100 && n0 < 5; c++) begin
      @(negedge clk); a0 = s0_valid && s0_ready;
      if (a0) first_wr = count_we(start, 1);
      @(posedge clk); #1;
      if (a0) begin n0++; s0_valid = 0; end
    end
    check("fifth_accept", 32'(n0), 32'd5);
    check("fifth_after_pop", 32'(first_wr), 32'd1);
    wait_wr(start, 5, "full_writes");
    wr_seq.delete();
    for (int k = start; k < txq.size(); k++) if (txq[k].we) wr_seq.push_back(txq[k].wdata[7:0]);
    for (int k = 0; k < 5 && k < wr_seq.size(); k++)
      check($sformatf("full_order%0d", k), 32'(wr_seq[k]), 32'(8'h30 + k));

    // ---- reset while a write waits on m_ready
    do_reset();
    start = txq.size();
    wr_rdy = 0;
    push0(8'h77);
    bad = 0;
    while (!(m_req && m_we) && bad < 50) begin @(posedge clk); #1 bad++; end
    check("wr_pending", 32'(m_req && m_we), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("wr_hold", {31'd0, m_req} | (32'(m_addr) ^ T), 32'd1);
    end
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst_req", 32'(m_req), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
`ifdef UART_SCHED_STATS_EN
    check("rst_stats", sent_cnt | retry_cnt, 32'd0);
`endif
    wr_rdy = 1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1 if (m_req) bad++; end
    check("rst_quiet", 32'(bad), 32'd0);
    start = txq.size();
    push0(8'h78);
    wait_wr(start, 1, "post_rst_write");
    for (int k = start; k < txq.size(); k++)
      if (txq[k].we) check("post_rst_data", txq[k].wdata, 32'h78);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
